// File: rtl/imm_gen_pkg.sv
// Shared types and opcode constants for the decode-stage immediate generator.
package imm_gen_pkg;

   localparam int XLEN_MAX = 64;

   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_S    = 3'd2,
      IMM_B    = 3'd3,
      IMM_U    = 3'd4,
      IMM_J    = 3'd5
   } imm_type_e;

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_IMM32  = 7'b0011011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_REG32  = 7'b0111011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;

   // Sized for the widest datapath; narrower builds zero the upper bits.
   typedef struct packed {
      imm_type_e             immType;
      logic [XLEN_MAX-1:0]   imm;
      logic [XLEN_MAX-1:0]   target;
      logic                  isShamt;
      logic                  illegal;
   } imm_res_t;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Handshake and result bus between the fetch side, the immediate stage and its consumer.
interface imm_gen_pipe_if #(
   parameter int XLEN = 32
);
   import imm_gen_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_instr;
   logic [XLEN-1:0]  in_pc;
   logic             out_valid;
   logic             out_ready;
   imm_type_e        out_type;
   logic [XLEN-1:0]  out_imm;
   logic [XLEN-1:0]  out_target;
   logic             out_is_shamt;
   logic             out_illegal;

   modport master (
      output in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_type, out_imm, out_target, out_is_shamt, out_illegal
   );

   modport slave (
      input  in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_type, out_imm, out_target, out_is_shamt, out_illegal
   );

endinterface

// File: rtl/imm_decode.sv
// Combinational opcode classifier and immediate/target extractor for one instruction.
module imm_decode
   import imm_gen_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int SHAMT_W = $clog2(XLEN)
) (
   input  logic [31:0]      instr_i,
   input  logic [XLEN-1:0]  pc_i,
   output imm_res_t         res_o
);

   logic [6:0]       opcode;
   logic [2:0]       funct3;
   imm_type_e        immType;
   logic [XLEN-1:0]  immX;
   logic [XLEN-1:0]  tgtX;
   logic             isShamt;
   logic             illegal;
   logic             pcRel;

   assign opcode = instr_i[6:0];
   assign funct3 = instr_i[14:12];

   // Signed casts widen each raw field with its top bit as the sign.
   always_comb begin
      immType = IMM_NONE;
      immX    = '0;
      isShamt = 1'b0;
      illegal = 1'b0;
      pcRel   = 1'b0;
      case (opcode)
         OP_IMM, OP_IMM32: begin
            immType = IMM_I;
            if (funct3 == 3'b001 || funct3 == 3'b101) begin
               isShamt = 1'b1;
               if (opcode == OP_IMM32) immX = XLEN'(instr_i[24:20]);
               else                    immX = XLEN'(instr_i[20 +: SHAMT_W]);
            end else begin
               immX = XLEN'($signed(instr_i[31:20]));
            end
         end
         OP_LOAD, OP_JALR, OP_SYSTEM: begin
            immType = IMM_I;
            immX    = XLEN'($signed(instr_i[31:20]));
         end
         OP_STORE: begin
            immType = IMM_S;
            immX    = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
         end
         OP_BRANCH: begin
            immType = IMM_B;
            pcRel   = 1'b1;
            immX    = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0}));
         end
         OP_LUI, OP_AUIPC: begin
            immType = IMM_U;
            pcRel   = (opcode == OP_AUIPC);
            immX    = XLEN'($signed({instr_i[31:12], 12'b0}));
         end
         OP_JAL: begin
            immType = IMM_J;
            pcRel   = 1'b1;
            immX    = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0}));
         end
         OP_REG, OP_REG32, OP_FENCE: begin
            immType = IMM_NONE;
         end
         default: begin
            illegal = 1'b1;
         end
      endcase
   end

   assign tgtX = pcRel ? (pc_i + immX) : '0;

   always_comb begin
      res_o         = '0;
      res_o.immType = immType;
      res_o.imm     = XLEN_MAX'(immX);
      res_o.target  = XLEN_MAX'(tgtX);
      res_o.isShamt = isShamt;
      res_o.illegal = illegal;
   end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate-generator stage with valid/ready on both sides and flush.
// Define IMM_GEN_PIPE_SKID_EN to add a skid entry so in_ready comes straight from a flop.
module imm_gen_pipe
   import imm_gen_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int SHAMT_W = $clog2(XLEN)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           flush,
   imm_gen_pipe_if.slave  bus
);

   imm_res_t  decRes;
   imm_res_t  outRes_q, outRes_d;
   logic      outValid_q, outValid_d;
   logic      accept;

   imm_decode #(
      .XLEN    (XLEN),
      .SHAMT_W (SHAMT_W)
   ) uDecode (
      .instr_i (bus.in_instr),
      .pc_i    (bus.in_pc),
      .res_o   (decRes)
   );

   assign accept = bus.in_valid && bus.in_ready;

`ifdef IMM_GEN_PIPE_SKID_EN
   imm_res_t  skidRes_q, skidRes_d;
   logic      skidValid_q, skidValid_d;

   assign bus.in_ready = !skidValid_q;

   // A full skid blocks input, so skid drains into out before anything new lands there.
   always_comb begin
      outValid_d  = outValid_q;
      outRes_d    = outRes_q;
      skidValid_d = skidValid_q;
      skidRes_d   = skidRes_q;
      if (skidValid_q) begin
         if (bus.out_ready) begin
            outRes_d    = skidRes_q;
            skidValid_d = 1'b0;
         end
      end else if (accept) begin
         if (!outValid_q || bus.out_ready) begin
            outValid_d = 1'b1;
            outRes_d   = decRes;
         end else begin
            skidValid_d = 1'b1;
            skidRes_d   = decRes;
         end
      end else if (bus.out_ready) begin
         outValid_d = 1'b0;
      end
      if (flush) begin
         outValid_d  = 1'b0;
         skidValid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         outValid_q  <= 1'b0;
         outRes_q    <= '0;
         skidValid_q <= 1'b0;
         skidRes_q   <= '0;
      end else begin
         outValid_q  <= outValid_d;
         outRes_q    <= outRes_d;
         skidValid_q <= skidValid_d;
         skidRes_q   <= skidRes_d;
      end
   end
`else
   assign bus.in_ready = !outValid_q || bus.out_ready;

   always_comb begin
      outValid_d = outValid_q;
      outRes_d   = outRes_q;
      if (accept) begin
         outValid_d = 1'b1;
         outRes_d   = decRes;
      end else if (bus.out_ready) begin
         outValid_d = 1'b0;
      end
      if (flush) outValid_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         outValid_q <= 1'b0;
         outRes_q   <= '0;
      end else begin
         outValid_q <= outValid_d;
         outRes_q   <= outRes_d;
      end
   end
`endif

   assign bus.out_valid    = outValid_q;
   assign bus.out_type     = outRes_q.immType;
   assign bus.out_imm      = outRes_q.imm[XLEN-1:0];
   assign bus.out_target   = outRes_q.target[XLEN-1:0];
   assign bus.out_is_shamt = outRes_q.isShamt;
   assign bus.out_illegal  = outRes_q.illegal;

   if (XLEN < XLEN_MAX) begin : gNarrow
      logic unusedHigh;
      assign unusedHigh = ^{outRes_q.imm[XLEN_MAX-1:XLEN], outRes_q.target[XLEN_MAX-1:XLEN]};
   end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Drives a 32-bit and a 64-bit instance with identical traffic and scores both against a queue model.
module tb_imm_gen_pipe;

   typedef struct {
      logic [2:0]   t;
      logic [63:0]  imm;
      logic [63:0]  tgt;
      logic         sh;
      logic         ill;
   } expT;

   typedef struct {
      logic [31:0]  ins;
      logic [63:0]  pc;
   } entT;

   logic clk;
   logic rst;
   logic flush;
   int   checks;
   int   errors;
   entT  sb[$];

   imm_gen_pipe_if #(.XLEN(32)) bus32 ();
   imm_gen_pipe_if #(.XLEN(64)) bus64 ();

   imm_gen_pipe #(.XLEN(32)) dut32 (.clk(clk), .rst(rst), .flush(flush), .bus(bus32));
   imm_gen_pipe #(.XLEN(64)) dut64 (.clk(clk), .rst(rst), .flush(flush), .bus(bus64));

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic longint sext(input longint v, input int n);
      if (((v >>> (n - 1)) & 1) != 0) return v - (longint'(1) << n);
      return v;
   endfunction

   // Reference: type codes NONE=0 I=1 S=2 B=3 U=4 J=5, everything reduced modulo 2^xlen.
   function automatic expT refModel(input logic [31:0] ins, input logic [63:0] pc, input int xlen);
      expT         e;
      longint      imm;
      bit          pcRel;
      logic [63:0] mask;
      logic [6:0]  op;
      logic [2:0]  f3;
      op    = ins[6:0];
      f3    = ins[14:12];
      mask  = (xlen == 64) ? {64{1'b1}} : 64'h0000_0000_FFFF_FFFF;
      e.t   = 3'd0;
      e.sh  = 1'b0;
      e.ill = 1'b0;
      imm   = 0;
      pcRel = 1'b0;
      case (op)
         7'b0010011, 7'b0011011: begin
            e.t = 3'd1;
            if (f3 == 3'b001 || f3 == 3'b101) begin
               e.sh = 1'b1;
               if (op == 7'b0011011 || xlen == 32) imm = longint'(ins[24:20]);
               else                               imm = longint'(ins[25:20]);
            end else begin
               imm = sext(longint'(ins[31:20]), 12);
            end
         end
         7'b0000011, 7'b1100111, 7'b1110011: begin
            e.t = 3'd1;
            imm = sext(longint'(ins[31:20]), 12);
         end
         7'b0100011: begin
            e.t = 3'd2;
            imm = sext(longint'(ins[31:25]) * 32 + longint'(ins[11:7]), 12);
         end
         7'b1100011: begin
            e.t   = 3'd3;
            pcRel = 1'b1;
            imm   = sext(longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
                         + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2, 13);
         end
         7'b0110111, 7'b0010111: begin
            e.t   = 3'd4;
            pcRel = (op == 7'b0010111);
            imm   = sext(longint'(ins[31:12]) * 4096, 32);
         end
         7'b1101111: begin
            e.t   = 3'd5;
            pcRel = 1'b1;
            imm   = sext(longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096
                         + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2, 21);
         end
         7'b0110011, 7'b0111011, 7'b0001111: e.t = 3'd0;
         default: e.ill = 1'b1;
      endcase
      e.imm = 64'(imm) & mask;
      e.tgt = pcRel ? ((pc + 64'(imm)) & mask) : 64'd0;
      return e;
   endfunction

   task automatic checkFront(input entT en);
      expT e32;
      expT e64;
      e32 = refModel(en.ins, en.pc, 32);
      e64 = refModel(en.ins, en.pc, 64);
      checkOutput("type32",  64'(bus32.out_type),     64'(e32.t));
      checkOutput("imm32",   64'(bus32.out_imm),      e32.imm);
      checkOutput("tgt32",   64'(bus32.out_target),   e32.tgt);
      checkOutput("shamt32", 64'(bus32.out_is_shamt), 64'(e32.sh));
      checkOutput("ill32",   64'(bus32.out_illegal),  64'(e32.ill));
      checkOutput("type64",  64'(bus64.out_type),     64'(e64.t));
      checkOutput("imm64",   bus64.out_imm,           e64.imm);
      checkOutput("tgt64",   bus64.out_target,        e64.tgt);
      checkOutput("shamt64", 64'(bus64.out_is_shamt), 64'(e64.sh));
      checkOutput("ill64",   64'(bus64.out_illegal),  64'(e64.ill));
   endtask

   // One clock: drive at negedge, check just after, advance the queue model at posedge.
   task automatic stepCycle(input bit v, input logic [31:0] ins, input logic [63:0] pc,
                            input bit rdy, input bit fl, input bit rs);
      int n;
      bit expReady;
      bit fireIn;
      bit fireOut;
      @(negedge clk);
      bus32.in_valid  = v;
      bus32.in_instr  = ins;
      bus32.in_pc     = pc[31:0];
      bus32.out_ready = rdy;
      bus64.in_valid  = v;
      bus64.in_instr  = ins;
      bus64.in_pc     = pc;
      bus64.out_ready = rdy;
      flush           = fl;
      rst             = rs;
      #1;
      n = sb.size();
`ifdef IMM_GEN_PIPE_SKID_EN
      expReady = (n < 2);
`else
      expReady = (n == 0) || rdy;
`endif
      checkOutput("out_valid32", 64'(bus32.out_valid), 64'(n > 0));
      checkOutput("out_valid64", 64'(bus64.out_valid), 64'(n > 0));
      checkOutput("in_ready32",  64'(bus32.in_ready),  64'(expReady));
      checkOutput("in_ready64",  64'(bus64.in_ready),  64'(expReady));
      if (n > 0) checkFront(sb[0]);
      fireIn  = v && expReady;
      fireOut = (n > 0) && rdy;
      @(posedge clk);
      if (rs || fl) begin
         sb.delete();
      end else begin
         if (fireOut) sb.delete(0);
         if (fireIn)  sb.push_back('{ins: ins, pc: pc});
      end
   endtask

   task automatic applyStimulus(input string tag, input logic [31:0] ins, input logic [63:0] pc,
                                input logic [2:0] t, input logic [63:0] imm32, input logic [63:0] tgt32,
                                input logic [63:0] imm64, input logic [63:0] tgt64,
                                input bit sh, input bit ill);
      stepCycle(1'b1, ins, pc, 1'b1, 1'b0, 1'b0);
      #1;
      checkOutput({tag, "_valid"},  64'(bus32.out_valid),    64'd1);
      checkOutput({tag, "_type32"}, 64'(bus32.out_type),     64'(t));
      checkOutput({tag, "_imm32"},  64'(bus32.out_imm),      imm32);
      checkOutput({tag, "_tgt32"},  64'(bus32.out_target),   tgt32);
      checkOutput({tag, "_type64"}, 64'(bus64.out_type),     64'(t));
      checkOutput({tag, "_imm64"},  bus64.out_imm,           imm64);
      checkOutput({tag, "_tgt64"},  bus64.out_target,        tgt64);
      checkOutput({tag, "_shamt"},  64'(bus64.out_is_shamt), 64'(sh));
      checkOutput({tag, "_ill"},    64'(bus64.out_illegal),  64'(ill));
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, "_valid32"}, 64'(bus32.out_valid),    64'd0);
      checkOutput({tag, "_type32"},  64'(bus32.out_type),     64'd0);
      checkOutput({tag, "_imm32"},   64'(bus32.out_imm),      64'd0);
      checkOutput({tag, "_tgt32"},   64'(bus32.out_target),   64'd0);
      checkOutput({tag, "_shamt32"}, 64'(bus32.out_is_shamt), 64'd0);
      checkOutput({tag, "_ill32"},   64'(bus32.out_illegal),  64'd0);
      checkOutput({tag, "_valid64"}, 64'(bus64.out_valid),    64'd0);
      checkOutput({tag, "_type64"},  64'(bus64.out_type),     64'd0);
      checkOutput({tag, "_imm64"},   bus64.out_imm,           64'd0);
      checkOutput({tag, "_tgt64"},   bus64.out_target,        64'd0);
      checkOutput({tag, "_shamt64"}, 64'(bus64.out_is_shamt), 64'd0);
      checkOutput({tag, "_ill64"},   64'(bus64.out_illegal),  64'd0);
   endtask

   function automatic logic [31:0] randInstr();
      logic [6:0]  opTab [13] = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0011011,
                                  7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
                                  7'b0110011, 7'b0111011, 7'b0001111};
      logic [31:0] r;
      int          idx;
      r   = $urandom();
      idx = int'($urandom_range(0, 15));
      if (idx < 13) r[6:0] = opTab[idx];
      return r;
   endfunction

   function automatic logic [63:0] randPc();
      return {$urandom(), $urandom()};
   endfunction

   initial begin
      clk    = 1'b0;
      rst    = 1'b1;
      flush  = 1'b0;
      checks = 0;
      errors = 0;
      bus32.in_valid = 1'b0; bus32.in_instr = '0; bus32.in_pc = '0; bus32.out_ready = 1'b0;
      bus64.in_valid = 1'b0; bus64.in_instr = '0; bus64.in_pc = '0; bus64.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkReset("rst_init");

      applyStimulus("addi",  32'hFFF00093, 64'h0, 3'd1, 64'hFFFF_FFFF, 64'd0,
                    {64{1'b1}}, 64'd0, 1'b0, 1'b0);
      applyStimulus("beq",   32'hFE000EE3, 64'h100, 3'd3, 64'hFFFF_FFFC, 64'h0000_00FC,
                    64'hFFFF_FFFF_FFFF_FFFC, 64'h0000_00FC, 1'b0, 1'b0);
      applyStimulus("jal",   32'h0080006F, 64'h200, 3'd5, 64'd8, 64'h208, 64'd8, 64'h208, 1'b0, 1'b0);
      applyStimulus("lui",   32'h800000B7, 64'h40, 3'd4, 64'h8000_0000, 64'd0,
                    64'hFFFF_FFFF_8000_0000, 64'd0, 1'b0, 1'b0);
      applyStimulus("slli",  32'h00309093, 64'h0, 3'd1, 64'd3, 64'd0, 64'd3, 64'd0, 1'b1, 1'b0);
      applyStimulus("slli63", 32'h03F09093, 64'h0, 3'd1, 64'd31, 64'd0, 64'd63, 64'd0, 1'b1, 1'b0);
      applyStimulus("srai",  32'h4050D093, 64'h0, 3'd1, 64'd5, 64'd0, 64'd5, 64'd0, 1'b1, 1'b0);
      applyStimulus("slliw", 32'h0210909B, 64'h0, 3'd1, 64'd1, 64'd0, 64'd1, 64'd0, 1'b1, 1'b0);
      applyStimulus("auipc", 32'h00001097, 64'hFFFF_FFFF_FFFF_F000, 3'd4, 64'h1000, 64'd0,
                    64'h1000, 64'd0, 1'b0, 1'b0);
      applyStimulus("jalr",  32'hFF0080E7, 64'h300, 3'd1, 64'hFFFF_FFF0, 64'd0,
                    64'hFFFF_FFFF_FFFF_FFF0, 64'd0, 1'b0, 1'b0);
      applyStimulus("add",   32'h00000033, 64'h0, 3'd0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0);
      applyStimulus("bad",   32'h0000007F, 64'h0, 3'd0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1);
      stepCycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);

      // Back-to-back offers into a stalled consumer, then drain.
      for (int i = 0; i < 4; i++) stepCycle(1'b1, randInstr(), randPc(), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) stepCycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);

      // Flush with a result held and a new input offered in the same cycle.
      stepCycle(1'b1, randInstr(), randPc(), 1'b0, 1'b0, 1'b0);
      stepCycle(1'b1, randInstr(), randPc(), 1'b0, 1'b1, 1'b0);
      stepCycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
      stepCycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);

      // Reset while stalled.
      stepCycle(1'b1, randInstr(), randPc(), 1'b0, 1'b0, 1'b0);
      stepCycle(1'b1, randInstr(), randPc(), 1'b0, 1'b0, 1'b0);
      stepCycle(1'b1, randInstr(), randPc(), 1'b0, 1'b0, 1'b1);
      #1;
      checkReset("rst_stall");
      stepCycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);

      for (int i = 0; i < 600; i++) begin
         stepCycle($urandom_range(0, 3) != 0, randInstr(), randPc(),
                   $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0,
                   $urandom_range(0, 90) == 0);
      end
      for (int i = 0; i < 3; i++) stepCycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Registered, parametrised immediate generator for the RISC-V core's decode stage.
- Classifies each instruction by opcode and extracts the sign-extended immediate to XLEN bits.
- For PC-relative formats, also produces the branch/jump/AUIPC target.
- One-cycle pipeline stage with valid/ready handshake on both sides plus synchronous flush; replaces the combinational per-format extender outputs with a single selected immediate.

Parameters:
- XLEN, 32, datapath width (32 or 64); immediate, PC and target width.
- SHAMT_W, $clog2(XLEN), width of shift-amount immediate for I-type shifts.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- flush  input  1  synchronous pipeline clear
- in_valid  input  1  instruction/PC pair valid
- in_ready  output  1  stage can accept input
- in_instr  input  32  instruction word
- in_pc  input  XLEN  PC of in_instr
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_type  output  3  imm_type_e: NONE/I/S/B/U/J
- out_imm  output  XLEN  sign-extended immediate
- out_target  output  XLEN  in_pc + out_imm for B, J, AUIPC; else 0
- out_is_shamt  output  1  immediate is a zero-extended shift amount
- out_illegal  output  1  opcode not in the RV32I/RV64I base set

Behaviour:
- Reset (rst=1 at edge): out_valid=0; out_type=NONE; out_imm, out_target, out_is_shamt and out_illegal all 0; skid entry emptied.
- Accept: input is taken when in_valid && in_ready; result appears on outputs the next cycle (latency 1).
- Output hold: while out_valid && !out_ready, all out_* remain stable.
- Without the optional skid buffer: in_ready = !out_valid || out_ready (combinational pass-through of out_ready).
- Opcode decode (in_instr[6:0]):
  - 0010011, 0000011, 1100111, 1110011, 0011011 -> I
  - 0100011 -> S
  - 1100011 -> B
  - 0110111, 0010111 -> U
  - 1101111 -> J
  - 0110011, 0111011, 0001111 -> NONE, imm=0
  - any other opcode -> NONE, imm=0, out_illegal=1
- Immediate formation:
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U: {instr[31:12], 12'b0}
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - All formats sign-extended from their top bit to XLEN; U-type is also sign-extended when XLEN=64.
- Shifts: for opcodes 0010011/0011011 with funct3 001 or 101:
  - out_imm = zero-extended instr[20+SHAMT_W-1:20]; out_is_shamt=1.
  - The funct7/funct6 field is excluded from the immediate.
  - For 0011011 the shamt is 5 bits regardless of XLEN.
- Target:
  - out_target = in_pc + imm, modulo 2^XLEN (wrap-around, no overflow flag).
  - Computed only for B, J and AUIPC (0010111); 0 for all other types including LUI and JALR.
- Flush:
  - Clears out_valid and the skid entry at the clock edge; any in_valid presented in the same cycle is dropped.
  - Priority: rst > flush > accept.
- Reset/flush asserted mid-stall: held data is discarded; no result is emitted afterward.

Optional Feature:
- Macro: IMM_GEN_PIPE_SKID_EN.
- When defined:
  - Adds a one-entry skid register so that in_ready is a flop output with no combinational path from out_ready.
  - in_ready = !skid_valid.
  - When out is stalled and a new input is accepted, the result goes to skid; skid moves to out when out_ready is seen.
  - Ordering is preserved; up to 2 results are in flight.
- When undefined: single output register; in_ready as described in Behaviour.

Decomposition:
- Package imm_gen_pkg:
  - imm_type_e enum (IMM_NONE=0, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J).
  - Opcode localparams (OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_IMM32, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_REG, OP_REG32, OP_FENCE).
  - Result struct imm_res_t {type, imm, target, is_shamt, illegal}.
- Sub-module: imm_decode, purely combinational: instr + pc -> imm_res_t. imm_gen_pipe contains only registers and handshake logic.

Test Plan:
- XLEN=32, 0xFFF00093 (addi x1,x0,-1) -> next cycle out_type=I, out_imm=0xFFFFFFFF, out_target=0.
- 0xFE000EE3 (beq, -4), pc=0x100 -> type=B, imm=0xFFFFFFFC, target=0x000000FC. Then 0x0080006F (jal, 8), pc=0x200 -> type=J, imm=8, target=0x208.
- XLEN=64, 0x800000B7 (lui x1,0x80000) -> type=U, imm=0xFFFFFFFF80000000, target=0. Then 0x00309093 (slli x1,x1,3) -> type=I, imm=3, is_shamt=1.
- 0x00000033 (add) -> NONE, imm=0, illegal=0. Then 0x0000007F -> NONE, illegal=1.
- Back-to-back in_valid with out_ready=0 for 3 cycles -> out_* stable, in_ready low (after 1 extra accept with SKID_EN). Release out_ready -> all results delivered in order, none lost or duplicated.
- flush pulsed while out_valid=1 and in_valid=1 -> next cycle out_valid=0 and the flushed input never appears. rst pulsed mid-stall -> all outputs back to their reset values.
